// File: rtl/run_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : run_sequencer                                                   |
// | Brief    : Core run controller and dat_mem host/core port arbiter.         |
// |            Optional core store counter enabled by RUN_SEQ_WRCOUNT_EN.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module run_sequencer #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = 4096,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_start,
  input  logic          host_mem_req,
  input  logic          host_mem_we,
  input  logic [AW-1:0] host_mem_addr,
  input  logic [DW-1:0] host_mem_wdata,
  output logic          host_mem_gnt,
  output logic [DW-1:0] host_mem_rdata,
  input  logic          core_mem_we,
  input  logic [AW-1:0] core_mem_addr,
  input  logic [DW-1:0] core_mem_wdata,
  output logic [DW-1:0] core_mem_rdata,
  output logic          core_reset,
  input  logic          core_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          run_done,
  output logic          timed_out,
  output logic [CW-1:0] cycle_count
`ifdef RUN_SEQ_WRCOUNT_EN
  ,
  output logic [CW-1:0] core_wr_count
`endif
);

  localparam int          c_RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [c_RW-1:0] c_RST_LAST = c_RW'(RST_CYC - 1);
  localparam logic [CW-1:0]   c_TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   c_TO       = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CRST = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_RW-1:0] r_rst_cnt;
  logic            r_core_reset;
  logic            r_busy;
  logic            r_run_done;
  logic            r_timed_out;
  logic [CW-1:0]   r_cycle_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rst_cnt     <= '0;
      r_core_reset  <= 1'b1;
      r_busy        <= 1'b0;
      r_run_done    <= 1'b0;
      r_timed_out   <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (host_start) begin
            r_state       <= S_CRST;
            r_busy        <= 1'b1;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
          end
        end
        S_CRST: begin
          if (r_rst_cnt == c_RST_LAST) begin
            r_state      <= S_RUN;
            r_rst_cnt    <= '0;
            r_core_reset <= 1'b0;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        S_RUN: begin
          // core_done takes priority over the timeout check in the same cycle
          if (core_done) begin
            r_state      <= S_DONE;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_run_done   <= 1'b1;
          end else if (r_cycle_count == c_TO_LAST) begin
            r_state       <= S_DONE;
            r_core_reset  <= 1'b1;
            r_busy        <= 1'b0;
            r_run_done    <= 1'b1;
            r_timed_out   <= 1'b1;
            r_cycle_count <= c_TO;
          end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_core_reset <= 1'b1;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign core_reset  = r_core_reset;
  assign busy        = r_busy;
  assign run_done    = r_run_done;
  assign timed_out   = r_timed_out;
  assign cycle_count = r_cycle_count;

  // Port mux keys off registered state only, so grants never glitch on inputs other than req.
  always_comb begin
    host_mem_gnt   = 1'b0;
    host_mem_rdata = '0;
    core_mem_rdata = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    if (r_state == S_IDLE && host_mem_req) begin
      host_mem_gnt   = 1'b1;
      mem_we         = host_mem_we;
      mem_addr       = host_mem_addr;
      mem_wdata      = host_mem_wdata;
      host_mem_rdata = mem_rdata;
    end else if (r_state == S_RUN) begin
      mem_we         = core_mem_we;
      mem_addr       = core_mem_addr;
      mem_wdata      = core_mem_wdata;
      core_mem_rdata = mem_rdata;
    end
  end

`ifdef RUN_SEQ_WRCOUNT_EN
  logic [CW-1:0] r_wr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (r_state == S_IDLE && host_start) begin
      r_wr_count <= '0;
    end else if (r_state == S_RUN && core_mem_we && r_wr_count != '1) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  assign core_wr_count = r_wr_count;
`endif

endmodule
`default_nettype wire
